mmio_fifo_bridge: RTL and testbench

- Parametrised MMIO-to-stream bridge between the host register interface and user logic.
- Provides NUM_CH independent channel pairs. Each pair has one host-to-user (TX) FIFO and one user-to-host (RX) FIFO.
- Adds per-channel status registers, error responses and valid/ready streaming on the user side.
- Sits between the CL register decode and user compute blocks (e.g. adder cores).

---
 rtl/mmio_fifo_bridge_pkg.sv | 29 ++
 rtl/mmio_fifo_bridge_sync_fifo.sv | 49 ++++
 rtl/mmio_fifo_bridge.sv | 194 +++++++++++++++++++
 tb/tb_mmio_fifo_bridge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_fifo_bridge_pkg.sv
// rtl/mmio_fifo_bridge_pkg.sv - shared offsets, response codes and read FSM states
// Optional DROPCNT register mapping controlled by MMIO_FIFO_BRIDGE_DROPCNT_EN.
package mmio_fifo_bridge_pkg;

    localparam logic [3:0] OFS_DATA    = 4'h0;
    localparam logic [3:0] OFS_STATUS  = 4'h4;
    localparam logic [3:0] OFS_DROPCNT = 4'h8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] EMPTY_READ_PATTERN = 32'hDEAD_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_RESP
    } rd_state_e;

    function automatic logic ofs_mapped(input logic [3:0] ofs);
`ifdef MMIO_FIFO_BRIDGE_DROPCNT_EN
        return (ofs == OFS_DATA) || (ofs == OFS_STATUS) || (ofs == OFS_DROPCNT);
`else
        return (ofs == OFS_DATA) || (ofs == OFS_STATUS);
`endif
    endfunction

endpackage

// File: rtl/mmio_fifo_bridge_sync_fifo.sv
// rtl/mmio_fifo_bridge_sync_fifo.sv - first-word-fall-through synchronous FIFO
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [AW:0]       diff;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign diff    = wptr - rptr;
    assign level   = diff;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_fifo_bridge.sv
// rtl/mmio_fifo_bridge.sv - MMIO to valid/ready stream bridge with per-channel TX/RX FIFOs
// Optional per-channel drop counter at +0x8 enabled by MMIO_FIFO_BRIDGE_DROPCNT_EN.
module mmio_fifo_bridge
    import mmio_fifo_bridge_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                NUM_CH    = 2,
    parameter int                DEPTH     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0600
) (
    input  logic                     clk_main_a0,
    input  logic                     rst_main,
    input  logic                     wr_valid,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_err,
    input  logic                     ar_valid,
    input  logic [ADDR_W-1:0]        ar_addr,
    output logic                     ar_ready,
    output logic                     r_valid,
    output logic [DATA_W-1:0]        r_data,
    output logic [1:0]               r_resp,
    input  logic                     r_ready,
    output logic [NUM_CH-1:0]        tx_valid,
    output logic [NUM_CH*DATA_W-1:0] tx_data,
    input  logic [NUM_CH-1:0]        tx_ready,
    input  logic [NUM_CH-1:0]        rx_valid,
    input  logic [NUM_CH*DATA_W-1:0] rx_data,
    output logic [NUM_CH-1:0]        rx_ready
);

    localparam int                CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                LVL_W = $clog2(DEPTH+1);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(16 * NUM_CH);

    logic [ADDR_W-1:0] wr_rel, rd_rel;
    logic              wr_hit, rd_hit, rd_accept;
    logic [CH_W-1:0]   wr_ch, rd_ch;
    logic [3:0]        wr_ofs, rd_ofs;

    logic [DATA_W-1:0] tx_head [NUM_CH];
    logic [DATA_W-1:0] rx_head [NUM_CH];
    logic [LVL_W-1:0]  tx_level [NUM_CH];
    logic [LVL_W-1:0]  rx_level [NUM_CH];
    logic [31:0]       status [NUM_CH];
    logic [NUM_CH-1:0] tx_full, tx_empty, rx_full, rx_empty;
    logic [NUM_CH-1:0] wr_sel, tx_push, tx_pop, tx_drop, rx_push, rx_pop;
    logic              wr_ok;
    rd_state_e         state;

    // Offsets are taken relative to BASE_ADDR; addresses below it wrap high and miss.
    assign wr_rel    = wr_addr - BASE_ADDR;
    assign rd_rel    = ar_addr - BASE_ADDR;
    assign wr_ofs    = wr_rel[3:0];
    assign rd_ofs    = rd_rel[3:0];
    assign wr_ch     = wr_rel[4 +: CH_W];
    assign rd_ch     = rd_rel[4 +: CH_W];
    assign wr_hit    = (wr_rel < SPAN) && ofs_mapped(wr_ofs);
    assign rd_hit    = (rd_rel < SPAN) && ofs_mapped(rd_ofs);
    assign rd_accept = ar_valid && ar_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign wr_sel[c]   = wr_valid && wr_hit && (wr_ch == CH_W'(c));
        assign tx_push[c]  = wr_sel[c] && (wr_ofs == OFS_DATA) && !tx_full[c];
        assign tx_drop[c]  = wr_sel[c] && (wr_ofs == OFS_DATA) && tx_full[c];
        assign tx_pop[c]   = tx_ready[c] && !tx_empty[c];
        assign rx_push[c]  = rx_valid[c] && rx_ready[c];
        assign rx_pop[c]   = rd_accept && rd_hit && (rd_ch == CH_W'(c))
                             && (rd_ofs == OFS_DATA) && !rx_empty[c];
        assign tx_valid[c] = !tx_empty[c];
        assign rx_ready[c] = !rx_full[c] && !rst_main;
        assign tx_data[c*DATA_W +: DATA_W] = tx_head[c];
        assign status[c]   = {tx_full[c], tx_empty[c], rx_full[c], rx_empty[c], 12'h000,
                              8'(tx_level[c]), 8'(rx_level[c])};

        sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
            .clk       (clk_main_a0),
            .rst       (rst_main),
            .push      (tx_push[c]),
            .push_data (wr_data),
            .pop       (tx_pop[c]),
            .head      (tx_head[c]),
            .full      (tx_full[c]),
            .empty     (tx_empty[c]),
            .level     (tx_level[c])
        );

        sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
            .clk       (clk_main_a0),
            .rst       (rst_main),
            .push      (rx_push[c]),
            .push_data (rx_data[c*DATA_W +: DATA_W]),
            .pop       (rx_pop[c]),
            .head      (rx_head[c]),
            .full      (rx_full[c]),
            .empty     (rx_empty[c]),
            .level     (rx_level[c])
        );
    end

`ifdef MMIO_FIFO_BRIDGE_DROPCNT_EN
    logic [15:0]       drop_cnt [NUM_CH];
    logic [NUM_CH-1:0] cnt_clr;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_clr
        assign cnt_clr[c] = wr_sel[c] && (wr_ofs == OFS_DROPCNT);
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            for (int c = 0; c < NUM_CH; c++) drop_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cnt_clr[c])
                    drop_cnt[c] <= '0;
                else if (tx_drop[c] && (drop_cnt[c] != 16'hFFFF))
                    drop_cnt[c] <= drop_cnt[c] + 16'd1;
            end
        end
    end

    assign wr_ok = (|tx_push) || (|cnt_clr);
`else
    assign wr_ok = |tx_push;
`endif

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) wr_err <= 1'b0;
        else          wr_err <= wr_valid && !wr_ok;
    end

    // Single outstanding read: ar_ready is only raised while idle.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            state    <= ST_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    ar_ready <= 1'b1;
                    if (rd_accept) begin
                        ar_ready <= 1'b0;
                        if (!rd_hit) begin
                            r_data  <= '0;
                            r_resp  <= RESP_DECERR;
                            r_valid <= 1'b1;
                            state   <= ST_RESP;
                        end else if (rd_ofs == OFS_DATA) begin
                            if (!rx_empty[rd_ch]) begin
                                r_data <= rx_head[rd_ch];
                                r_resp <= RESP_OKAY;
                                state  <= ST_POP;
                            end else begin
                                r_data  <= DATA_W'(EMPTY_READ_PATTERN);
                                r_resp  <= RESP_SLVERR;
                                r_valid <= 1'b1;
                                state   <= ST_RESP;
                            end
`ifdef MMIO_FIFO_BRIDGE_DROPCNT_EN
                        end else if (rd_ofs == OFS_DROPCNT) begin
                            r_data  <= DATA_W'(drop_cnt[rd_ch]);
                            r_resp  <= RESP_OKAY;
                            r_valid <= 1'b1;
                            state   <= ST_RESP;
`endif
                        end else begin
                            r_data  <= DATA_W'(status[rd_ch]);
                            r_resp  <= RESP_OKAY;
                            r_valid <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_POP: begin
                    r_valid <= 1'b1;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (r_ready) begin
                        r_valid  <= 1'b0;
                        ar_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_fifo_bridge.sv
// tb/tb_mmio_fifo_bridge.sv - scoreboard bench for mmio_fifo_bridge
// Expectations for +0x8 follow MMIO_FIFO_BRIDGE_DROPCNT_EN.
module tb_mmio_fifo_bridge;

    localparam logic [31:0] BASE = 32'h0000_0600;

    logic        clk = 1'b0;
    logic        rst_main;
    logic        wr_valid;
    logic [31:0] wr_addr, wr_data;
    logic        wr_err;
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_ready;
    logic [1:0]  tx_valid, tx_ready, rx_valid, rx_ready;
    logic [63:0] tx_data, rx_data;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mmio_fifo_bridge dut (
        .clk_main_a0 (clk),
        .rst_main    (rst_main),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .ar_valid    (ar_valid),
        .ar_addr     (ar_addr),
        .ar_ready    (ar_ready),
        .r_valid     (r_valid),
        .r_data      (r_data),
        .r_resp      (r_resp),
        .r_ready     (r_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (!rst_main && r_valid && r_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_resp: got %h/%0d expected none", r_data, r_resp);
            end else begin
                e = sb.pop_front();
                check("r_data", r_data, e.data);
                check("r_resp", {30'b0, r_resp}, {30'b0, e.resp});
            end
        end
    end

    task automatic expect_rsp(input logic [31:0] d, input logic [1:0] r);
        rsp_t e;
        e.data = d;
        e.resp = r;
        sb.push_back(e);
    endtask

    task automatic mmio_write(input logic [31:0] a, input logic [31:0] d, input logic exp_err);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        check("wr_err", {31'b0, wr_err}, {31'b0, exp_err});
    endtask

    task automatic wait_rvalid(input int exp_lat);
        int n;
        n = 1;
        while (!r_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rd_latency", n, exp_lat);
    endtask

    task automatic issue_read(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] r, input int exp_lat);
        int n;
        expect_rsp(d, r);
        ar_valid = 1'b1;
        ar_addr  = a;
        n = 0;
        while (!ar_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ar_ready_wait", {31'b0, ar_ready}, 32'd1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        wait_rvalid(exp_lat);
    endtask

    task automatic finish_read();
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] r, input int exp_lat);
        issue_read(a, d, r, exp_lat);
        finish_read();
    endtask

    task automatic pop_tx(input int ch);
        tx_ready[ch] = 1'b1;
        @(posedge clk); #1;
        tx_ready[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_main = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        ar_valid = 1'b0; ar_addr = '0; r_ready = 1'b1;
        tx_ready = '0; rx_valid = '0; rx_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rx_ready_in_reset", {30'b0, rx_ready}, 32'h0);
        rst_main = 1'b0;
        #1;
        check("reset_ar_ready", {31'b0, ar_ready}, 32'h0);
        check("reset_r_valid", {31'b0, r_valid}, 32'h0);
        check("reset_r_data", r_data, 32'h0);
        check("reset_r_resp", {30'b0, r_resp}, 32'h0);
        check("reset_wr_err", {31'b0, wr_err}, 32'h0);
        check("reset_tx_valid", {30'b0, tx_valid}, 32'h0);
        check("reset_rx_ready", {30'b0, rx_ready}, 32'h3);

        // ch0 TX path and STATUS
        mmio_write(BASE, 32'h11, 1'b0);
        mmio_write(BASE, 32'h22, 1'b0);
        check("tx0_valid", {31'b0, tx_valid[0]}, 32'h1);
        check("tx0_head_first", tx_data[31:0], 32'h11);
        do_read(BASE + 32'h4, 32'h1000_0200, 2'b00, 1);
        pop_tx(0);
        check("tx0_head_second", tx_data[31:0], 32'h22);
        pop_tx(0);
        check("tx0_drained", {31'b0, tx_valid[0]}, 32'h0);
        do_read(BASE + 32'h4, 32'h5000_0000, 2'b00, 1);

        // ch1 overflow
        for (int i = 0; i < 16; i++) mmio_write(BASE + 32'h10, 32'h100 + i, 1'b0);
        mmio_write(BASE + 32'h10, 32'hBAD, 1'b1);
        check("tx1_head", tx_data[63:32], 32'h100);
        do_read(BASE + 32'h14, 32'h9000_1000, 2'b00, 1);
`ifdef MMIO_FIFO_BRIDGE_DROPCNT_EN
        do_read(BASE + 32'h18, 32'h1, 2'b00, 1);
        mmio_write(BASE + 32'h18, 32'h1234, 1'b0);
        do_read(BASE + 32'h18, 32'h0, 2'b00, 1);
`else
        do_read(BASE + 32'h18, 32'h0, 2'b11, 1);
        mmio_write(BASE + 32'h18, 32'h0, 1'b1);
`endif
        mmio_write(BASE + 32'h4, 32'h0, 1'b1);
        mmio_write(32'h0, 32'h0, 1'b1);
        mmio_write(BASE + 32'h20, 32'h0, 1'b1);

        // ch0 RX pop and empty read
        rx_valid[0] = 1'b1;
        rx_data[31:0] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rx_valid[0] = 1'b0;
        do_read(BASE, 32'hCAFE_F00D, 2'b00, 2);
        do_read(BASE, 32'hDEAD_0000, 2'b10, 1);

        // unmapped read held under back-pressure
        r_ready = 1'b0;
        issue_read(BASE + 32'hC, 32'h0, 2'b11, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_r_valid", {31'b0, r_valid}, 32'h1);
            check("hold_r_data", r_data, 32'h0);
            check("hold_r_resp", {30'b0, r_resp}, 32'h3);
            check("hold_ar_ready", {31'b0, ar_ready}, 32'h0);
        end
        r_ready = 1'b1;
        finish_read();
        do_read(32'h0, 32'h0, 2'b11, 1);

        // same-cycle TX push and pop on a half-full FIFO
        for (int i = 0; i < 8; i++) mmio_write(BASE, 32'h200 + i, 1'b0);
        wr_valid = 1'b1; wr_addr = BASE; wr_data = 32'h2FF;
        tx_ready[0] = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        tx_ready[0] = 1'b0;
        check("conc_wr_err", {31'b0, wr_err}, 32'h0);
        check("conc_tx_head", tx_data[31:0], 32'h201);
        do_read(BASE + 32'h4, 32'h1000_0800, 2'b00, 1);

        // same-cycle RX push and MMIO pop on ch1
        rx_valid[1] = 1'b1;
        rx_data[63:32] = 32'hA1;
        @(posedge clk); #1;
        rx_data[63:32] = 32'hA2;
        @(posedge clk); #1;
        expect_rsp(32'hA1, 2'b00);
        check("conc_ar_ready", {31'b0, ar_ready}, 32'h1);
        ar_valid = 1'b1;
        ar_addr  = BASE + 32'h10;
        rx_data[63:32] = 32'hA3;
        @(posedge clk); #1;
        ar_valid = 1'b0;
        rx_valid[1] = 1'b0;
        wait_rvalid(2);
        finish_read();
        do_read(BASE + 32'h14, 32'h8000_1002, 2'b00, 1);
        do_read(BASE + 32'h10, 32'hA2, 2'b00, 2);
        do_read(BASE + 32'h10, 32'hA3, 2'b00, 2);

        // reset while the read FSM is in POP
        rx_valid[0] = 1'b1;
        rx_data[31:0] = 32'h77;
        @(posedge clk); #1;
        rx_valid[0] = 1'b0;
        check("pre_rst_ar_ready", {31'b0, ar_ready}, 32'h1);
        ar_valid = 1'b1;
        ar_addr  = BASE;
        @(posedge clk); #1;
        ar_valid = 1'b0;
        #2;
        rst_main = 1'b1;
        #1;
        check("rst_r_valid", {31'b0, r_valid}, 32'h0);
        check("rst_ar_ready", {31'b0, ar_ready}, 32'h0);
        check("rst_rx_ready", {30'b0, rx_ready}, 32'h0);
        @(posedge clk); #1;
        check("rst_r_valid_held", {31'b0, r_valid}, 32'h0);
        @(posedge clk); #1;
        rst_main = 1'b0;
        check("post_rst_tx_valid", {30'b0, tx_valid}, 32'h0);
        do_read(BASE + 32'h4, 32'h5000_0000, 2'b00, 1);
        do_read(BASE + 32'h14, 32'h5000_0000, 2'b00, 1);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
